sev_seg_reader: RTL and testbench

- Readback monitor for the D2 clock's multiplexed seven-segment display.
- Samples the cathode-driven segment lines (ABCDEFG, active-low) and the one-hot digit enables.
- Waits for each digit to be stable, then converts the segment pattern back to BCD and stores it per digit.
- Reports updates, illegal patterns and completed frames to the self-test logic.

---
 rtl/sev_seg_reader.sv | 153 +++++++++++++++
 tb/tb_sev_seg_reader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sev_seg_reader.sv
// rtl/sev_seg_reader.sv - seven-segment display readback monitor
module sev_seg_reader #(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 2,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  upd,
    output logic [IDX_W-1:0]      upd_idx,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  frame_done
);

    localparam int CNT_W = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t state, state_n;

    logic [6:0]        seg_m, seg_s, seg_p;
    logic [DIGITS-1:0] en_m, en_s, en_p;
    logic [CNT_W-1:0]  cnt;
    logic              changed;
    logic              eval;
    logic              multi_hot;
    logic [IDX_W-1:0]  idx;
    logic              legal;
    logic [3:0]        value;

    // Returns {legal, value}; active-low segments A..G in bits 6..0.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0000001: seg_decode = {1'b1, 4'd0};
            7'b1001111: seg_decode = {1'b1, 4'd1};
            7'b0010010: seg_decode = {1'b1, 4'd2};
            7'b0000110: seg_decode = {1'b1, 4'd3};
            7'b1001100: seg_decode = {1'b1, 4'd4};
            7'b0100100: seg_decode = {1'b1, 4'd5};
            7'b0100000: seg_decode = {1'b1, 4'd6};
            7'b0001111: seg_decode = {1'b1, 4'd7};
            7'b0000000: seg_decode = {1'b1, 4'd8};
            7'b0000100: seg_decode = {1'b1, 4'd9};
            default:    seg_decode = {1'b0, 4'd0};
        endcase
    endfunction

    // Previous-sample registers reset to the same values as the synchronisers
    // so that leaving reset with idle inputs is not seen as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= SEG_BLANK;
            seg_s <= SEG_BLANK;
            seg_p <= SEG_BLANK;
            en_m  <= '0;
            en_s  <= '0;
            en_p  <= '0;
            cnt   <= '0;
        end else begin
            seg_m <= seg;
            seg_s <= seg_m;
            seg_p <= seg_s;
            en_m  <= dig_en;
            en_s  <= en_m;
            en_p  <= en_s;
            if (changed)
                cnt <= CNT_W'(1);
            else if (cnt < CNT_W'(STABLE))
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign changed   = (seg_s != seg_p) || (en_s != en_p);
    assign multi_hot = (en_s & (en_s - DIGITS'(1))) != '0;
    assign {legal, value} = seg_decode(seg_s);

    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (en_s[i])
                idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        eval    = 1'b0;
        if (en_s == '0) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:  state_n = COUNT;
                COUNT: begin
                    if (!changed && cnt == CNT_W'(STABLE)) begin
                        eval    = 1'b1;
                        state_n = HOLD;
                    end
                end
                HOLD:  if (changed) state_n = COUNT;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd         <= '0;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            frame_done  <= 1'b0;
        end else begin
            upd        <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            if (eval) begin
                if (multi_hot) begin
                    err      <= 1'b1;
                    err_code <= 2'b10;
                end else if (legal) begin
                    bcd[4*idx +: 4]  <= value;
                    digit_valid[idx] <= 1'b1;
                    upd              <= 1'b1;
                    upd_idx          <= idx;
                    // en_s is one-hot here, so OR-ing it in includes this write.
                    frame_done <= (idx == IDX_W'(DIGITS - 1)) && (&(digit_valid | en_s));
                end else if (seg_s == SEG_BLANK) begin
                    digit_valid[idx] <= 1'b0;
                    upd              <= 1'b1;
                    upd_idx          <= idx;
                end else begin
                    err      <= 1'b1;
                    err_code <= 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_reader.sv
// tb/tb_sev_seg_reader.sv - self-checking bench for sev_seg_reader
module tb_sev_seg_reader;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] bcd;
    logic [3:0]  digit_valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;
    logic [1:0]  err_code;
    logic        frame_done;

    sev_seg_reader #(.DIGITS(4), .IDX_W(2), .STABLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_en(dig_en),
        .bcd(bcd), .digit_valid(digit_valid), .upd(upd), .upd_idx(upd_idx),
        .err(err), .err_code(err_code), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] en;
        int         hold;
        int         ev;      // 0 none, 1 upd, 2 err
        int         idx;
        logic [1:0] code;
        logic [3:0] val;
        bit         frame;
    } vec_t;

    typedef struct {
        int         kind;
        int         idx;
        logic [1:0] code;
        bit         frame;
        int         cyc;
    } exp_t;

    exp_t q[$];
    vec_t vt[16];
    logic [15:0] mbcd;
    logic [3:0]  mvalid;

    task automatic chk(input string name, input int act, input int req);
        ntests++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (upd || err || frame_done) begin
            if (upd && err) chk("upd_err_coincide", 1, 0);
            if (q.size() == 0) begin
                chk("unexpected_event", {29'd0, upd, err, frame_done}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_kind", upd ? 1 : 2, e.kind);
                chk("event_cycle", cyc, e.cyc);
                chk("frame_done", int'(frame_done), int'(e.frame));
                if (e.kind == 1) chk("upd_idx", int'(upd_idx), e.idx);
                else             chk("err_code", int'(err_code), int'(e.code));
            end
        end
    end

    task automatic check_regs(input string tag);
        chk({tag, "_pending"}, q.size(), 0);
        q.delete();
        chk({tag, "_bcd"}, int'(bcd), int'(mbcd));
        chk({tag, "_valid"}, int'(digit_valid), int'(mvalid));
    endtask

    initial begin
        vt[0]  = '{7'b0000110, 4'b0001, 10, 1, 0, 2'b00, 4'd3, 1'b0};
        vt[1]  = '{7'b1001111, 4'b0001,  8, 1, 0, 2'b00, 4'd1, 1'b0};
        vt[2]  = '{7'b0010010, 4'b0010,  8, 1, 1, 2'b00, 4'd2, 1'b0};
        vt[3]  = '{7'b0100100, 4'b0100,  8, 1, 2, 2'b00, 4'd5, 1'b0};
        vt[4]  = '{7'b0000100, 4'b1000,  8, 1, 3, 2'b00, 4'd9, 1'b1};
        vt[5]  = '{7'b0000001, 4'b0100,  3, 0, 0, 2'b00, 4'd0, 1'b0};
        vt[6]  = '{7'b0000000, 4'b0100,  8, 1, 2, 2'b00, 4'd8, 1'b0};
        vt[7]  = '{7'b1110000, 4'b0010,  8, 2, 0, 2'b01, 4'd0, 1'b0};
        vt[8]  = '{7'b0000001, 4'b0011,  8, 2, 0, 2'b10, 4'd0, 1'b0};
        vt[9]  = '{7'b1111111, 4'b0010,  8, 1, 1, 2'b00, 4'd0, 1'b0};
        vt[10] = '{7'b0000001, 4'b1000,  8, 1, 3, 2'b00, 4'd0, 1'b0};
        vt[11] = '{7'b1001111, 4'b0010,  8, 1, 1, 2'b00, 4'd1, 1'b0};
        vt[12] = '{7'b0100000, 4'b1000,  8, 1, 3, 2'b00, 4'd6, 1'b1};
        vt[13] = '{7'b0001111, 4'b0001,  8, 1, 0, 2'b00, 4'd7, 1'b0};
        vt[14] = '{7'b0000001, 4'b0000,  8, 0, 0, 2'b00, 4'd0, 1'b0};
        vt[15] = '{7'b1111111, 4'b0001,  8, 1, 0, 2'b00, 4'd0, 1'b0};

        rst_n  = 1'b0;
        seg    = 7'b1111111;
        dig_en = 4'b0000;
        mbcd   = '0;
        mvalid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bcd", int'(bcd), 0);
        chk("rst_valid", int'(digit_valid), 0);
        chk("rst_pulses", int'({upd, err, frame_done}), 0);
        chk("rst_held", int'({upd_idx, err_code}), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_regs("idle");

        for (int v = 0; v < 16; v++) begin
            seg    = vt[v].seg;
            dig_en = vt[v].en;
            if (vt[v].ev != 0)
                q.push_back('{vt[v].ev, vt[v].idx, vt[v].code, vt[v].frame, cyc + 7});
            if (vt[v].ev == 1) begin
                if (vt[v].seg == 7'b1111111) begin
                    mvalid[vt[v].idx] = 1'b0;
                end else begin
                    mbcd[vt[v].idx*4 +: 4] = vt[v].val;
                    mvalid[vt[v].idx]      = 1'b1;
                end
            end
            repeat (vt[v].hold) @(negedge clk);
            #1;
            check_regs($sformatf("vec%0d", v));
        end

        // Reset in the middle of a count: everything clears, capture abandoned.
        seg    = 7'b0000110;
        dig_en = 4'b0001;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd", int'(bcd), 0);
        chk("midrst_valid", int'(digit_valid), 0);
        chk("midrst_pulses", int'({upd, err, frame_done}), 0);
        chk("midrst_held", int'({upd_idx, err_code}), 0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mbcd   = 16'h0003;
        mvalid = 4'b0001;
        q.push_back('{1, 0, 2'b00, 1'b0, cyc + 7});
        repeat (12) @(negedge clk);
        #1;
        check_regs("post_rst");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
